aes_stream_frontend: RTL and testbench
======================================

AES_STREAM_FRONTEND -- requirements
Module: aes_stream_frontend

Interface
REQ-001 SHALL have parameter BUS_W, default 8, meaning input beat width; legal values are 8, 16, 32; BEATS = 128/BUS_W.
REQ-002 SHALL have parameter DEPTH, default 4, meaning plaintext block FIFO depth; power of 2, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-005 SHALL have port din, input, BUS_W bits, the data beat.
REQ-006 SHALL have port cmd, input, 2 bits: 00 idle, 01 key beat, 10 plaintext beat, 11 IV beat.
REQ-007 SHALL have port mode, input, 1 bit: 0 ECB, 1 CBC; it is sampled when the last key beat is accepted.
REQ-008 SHALL have port ready, output, 1 bit: a plaintext beat is accepted this cycle.
REQ-009 SHALL have port cfg_ready, output, 1 bit: a key or IV beat is accepted this cycle.
REQ-010 SHALL have port engine_start, output, 1 bit: one-cycle start pulse to the key generator.
REQ-011 SHALL have port plain_out, output, 128 bits: the block presented to the transformer.
REQ-012 SHALL have port key_out, output, 128 bits: the committed cipher key.
REQ-013 SHALL have port engine_done, input, 1 bit: the transformer-done pulse.
REQ-014 SHALL have port cipher_in, input, 128 bits: the transformer ciphertext, valid while engine_done=1.
REQ-015 SHALL have port fifo_count, output, $clog2(DEPTH)+1 bits: the number of queued blocks.
REQ-016 SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-017 SHALL assemble blocks MSB-first: first beat lands in bits [127:128-BUS_W], and the counter wraps after BEATS beats.
REQ-018 SHALL set ready = (fifo_count < DEPTH), combinationally.
REQ-019 SHALL set cfg_ready = (state==IDLE && fifo_count==0), combinationally.
REQ-020 SHALL drop a beat presented with the matching ready low, and set err.
REQ-021 SHALL hold a partial block unchanged while cmd=00.
REQ-022 SHALL discard a partial block and set err when a beat of a different non-idle cmd type arrives; that beat becomes beat 0 of its own type.
REQ-023 SHALL commit key_out and the mode register, and set key_valid, only on the cycle the last key beat is accepted; partial key loads never alter key_out.
REQ-024 SHALL, on the last IV beat, load the chain register with the IV.
REQ-025 SHALL, on the last plaintext beat, push the completed block into the FIFO on the same edge.
REQ-026 SHALL implement a dispatch FSM IDLE -> START -> BUSY -> IDLE.
- IDLE -> START when FIFO is non-empty and key_valid=1.
- START: engine_start=1 for exactly one cycle; plain_out = head, or head XOR chain in CBC; plain_out is held stable through BUSY.
- BUSY: wait for engine_done; on engine_done, pop head, latch chain<=cipher_in if CBC, go to IDLE.
REQ-027 SHALL ignore engine_done outside BUSY.
REQ-028 SHALL leave fifo_count unchanged when a push and a pop occur in the same cycle.
REQ-029 SHALL give a 2-cycle latency from the final plaintext beat edge to the engine_start pulse when idle and key_valid=1.
REQ-030 SHALL clear err only by reset.

Reset
REQ-031 SHALL, while rst_=1, clear immediately: engine_start=0, plain_out=0, key_out=0, key_valid=0, mode=ECB, chain=0, fifo_count=0, err=0, beat counter=0, state=IDLE.
REQ-032 SHALL abandon an in-flight block on reset; an engine_done arriving after reset is ignored.

Structure
REQ-033 SHALL place the following in shared package aes_pkg: cmd encodings, BLOCK_W=128, mode constants, and FSM state encoding.
REQ-034 SHALL implement the FIFO as sub-module aes_block_fifo, parameterised by DEPTH and width 128, with push/pop/full/empty/count ports.

Verification
REQ-035 SHALL cover ECB, BUS_W=8: key 000102..0f (16 beats), then plaintext 00112233..eeff -> one engine_start pulse 2 cycles later, key_out=000102..0f, plain_out=00112233445566778899aabbccddeeff.
REQ-036 SHALL cover CBC, BUS_W=32: IV=ffff..ff, then two blocks of zeros; engine_done with cipher_in=69c4e0d86a7b0430d8cdb78070b4c55a -> first plain_out=ff..ff, second plain_out=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-037 SHALL cover FIFO full with DEPTH=4 and no engine_done: 5 blocks sent -> fifo_count=4 (one in BUSY, not popped), ready=0, fifth block's beats dropped, err=1.
REQ-038 SHALL cover mixed cmd: 3 plaintext beats then a key beat -> partial discarded, err=1, key counter=1.
REQ-039 SHALL cover simultaneous push/pop: final plaintext beat on the same cycle as engine_done -> fifo_count unchanged, next START follows.
REQ-040 SHALL cover reset in BUSY: assert rst_, then pulse engine_done -> all outputs zero, no engine_start, fifo_count=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared encodings for the AES stream front end: command codes, block width,
// cipher mode constants and dispatch FSM states.
package aes_pkg;

  localparam int unsigned BLOCK_W = 128;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_KEY  = 2'b01,
    CMD_PT   = 2'b10,
    CMD_IV   = 2'b11
  } cmd_e;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

endpackage

// File: rtl/aes_block_fifo.sv
// Plaintext block FIFO: power-of-two depth, head is visible combinationally,
// a push and a pop on the same edge leave the occupancy unchanged.
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = BLOCK_W
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign head      = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= AW'(r_wr_ptr + 1'b1);
      if (w_pop_ok)  r_rd_ptr <= AW'(r_rd_ptr + 1'b1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/aes_stream_frontend.sv
// AES stream front end: assembles key/IV/plaintext beats MSB-first into 128-bit
// blocks, queues plaintext blocks and dispatches them to the engine in ECB or CBC.
module aes_stream_frontend
  import aes_pkg::*;
#(
  parameter int unsigned BUS_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [BUS_W-1:0]       din,
  input  logic [1:0]             cmd,
  input  logic                   mode,
  output logic                   ready,
  output logic                   cfg_ready,
  output logic                   engine_start,
  output logic [BLOCK_W-1:0]     plain_out,
  output logic [BLOCK_W-1:0]     key_out,
  input  logic                   engine_done,
  input  logic [BLOCK_W-1:0]     cipher_in,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err
);

  localparam int unsigned BEATS = BLOCK_W / BUS_W;
  localparam int unsigned CNT_W = $clog2(BEATS);

  state_e             r_state;
  cmd_e               r_part_type;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [BLOCK_W-1:0] r_asm;
  logic [BLOCK_W-1:0] r_chain;
  logic               r_key_valid;
  logic               r_mode;

  cmd_e               w_cmd;
  logic               w_beat;
  logic               w_accept;
  logic               w_mix;
  logic               w_last;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [BLOCK_W-1:0] w_block;
  logic [BLOCK_W-1:0] w_head;

  assign w_cmd     = cmd_e'(cmd);
  assign w_beat    = (w_cmd != CMD_IDLE);
  assign ready     = !w_full;
  assign cfg_ready = (r_state == ST_IDLE) && w_empty;
  assign w_accept  = w_beat && ((w_cmd == CMD_PT) ? ready : cfg_ready);
  // A beat of another type abandons the partial block and restarts at beat 0.
  assign w_mix     = w_beat && (r_beat_cnt != '0) && (w_cmd != r_part_type);
  assign w_last    = w_accept && !w_mix && (r_beat_cnt == CNT_W'(BEATS - 1));
  assign w_block   = {r_asm[BLOCK_W-BUS_W-1:0], din};
  assign w_push    = w_last && (w_cmd == CMD_PT);
  assign w_pop     = (r_state == ST_BUSY) && engine_done;

  aes_block_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BLOCK_W)
  ) u_fifo (
    .clk       (clk),
    .rst_      (rst_),
    .push      (w_push),
    .push_data (w_block),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (fifo_count)
  );

  // Beat assembly, key commit and sticky protocol error.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_beat_cnt  <= '0;
      r_part_type <= CMD_IDLE;
      r_asm       <= '0;
      key_out     <= '0;
      r_key_valid <= 1'b0;
      r_mode      <= MODE_ECB;
      err         <= 1'b0;
    end else begin
      if (w_mix || (w_beat && !w_accept)) err <= 1'b1;
      if (w_mix) r_beat_cnt <= '0;
      if (w_accept) begin
        r_asm       <= w_block;
        r_part_type <= w_cmd;
        if (w_last)     r_beat_cnt <= '0;
        else if (w_mix) r_beat_cnt <= CNT_W'(1);
        else            r_beat_cnt <= CNT_W'(r_beat_cnt + 1'b1);
      end
      if (w_last && (w_cmd == CMD_KEY)) begin
        key_out     <= w_block;
        r_mode      <= mode;
        r_key_valid <= 1'b1;
      end
    end
  end

  // Dispatch FSM; plain_out is captured in START and held through BUSY.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_state      <= ST_IDLE;
      engine_start <= 1'b0;
      plain_out    <= '0;
      r_chain      <= '0;
    end else begin
      engine_start <= 1'b0;
      if (w_last && (w_cmd == CMD_IV)) r_chain <= w_block;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty && r_key_valid) r_state <= ST_START;
        end
        ST_START: begin
          engine_start <= 1'b1;
          plain_out    <= (r_mode == MODE_CBC) ? (w_head ^ r_chain) : w_head;
          r_state      <= ST_BUSY;
        end
        ST_BUSY: begin
          if (engine_done) begin
            if (r_mode == MODE_CBC) r_chain <= cipher_in;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_frontend.sv
// Bench for aes_stream_frontend: an 8-bit-bus and a 32-bit-bus instance driven by
// directed vectors, checked every cycle against a transaction-level model.
module tb_aes_stream_frontend;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  i_din    [2];
  logic [1:0]   i_cmd    [2];
  logic         i_mode   [2];
  logic         i_done   [2];
  logic [127:0] i_cipher [2];

  logic         o_ready [2];
  logic         o_cfg   [2];
  logic         o_start [2];
  logic [127:0] o_plain [2];
  logic [127:0] o_key   [2];
  logic [2:0]   o_cnt   [2];
  logic         o_err   [2];

  int n_checks = 0;
  int n_fail   = 0;

  aes_stream_frontend #(.BUS_W(8), .DEPTH(4)) u_dut8 (
    .clk(clk), .rst_(rst_), .din(i_din[0][7:0]), .cmd(i_cmd[0]), .mode(i_mode[0]),
    .ready(o_ready[0]), .cfg_ready(o_cfg[0]), .engine_start(o_start[0]),
    .plain_out(o_plain[0]), .key_out(o_key[0]), .engine_done(i_done[0]),
    .cipher_in(i_cipher[0]), .fifo_count(o_cnt[0]), .err(o_err[0])
  );

  aes_stream_frontend #(.BUS_W(32), .DEPTH(4)) u_dut32 (
    .clk(clk), .rst_(rst_), .din(i_din[1]), .cmd(i_cmd[1]), .mode(i_mode[1]),
    .ready(o_ready[1]), .cfg_ready(o_cfg[1]), .engine_start(o_start[1]),
    .plain_out(o_plain[1]), .key_out(o_key[1]), .engine_done(i_done[1]),
    .cipher_in(i_cipher[1]), .fifo_count(o_cnt[1]), .err(o_err[1])
  );

  // Transaction-level model: block queue, partial-block beat list, engine job.
  logic [127:0] m_fifo [2][4];
  int           m_head [2];
  int           m_cnt  [2];
  int           m_plen [2];
  logic [1:0]   m_ptype[2];
  logic [127:0] m_pblk [2];
  logic [127:0] m_key  [2];
  logic [127:0] m_chain[2];
  logic [127:0] m_plain[2];
  bit           m_kv[2], m_mode[2], m_err[2], m_busy[2], m_started[2], m_start[2];

  always @(posedge clk or posedge rst_) begin
    for (int d = 0; d < 2; d++) begin
      int w;
      int nb;
      int pre_cnt;
      bit pre_cfg;
      bit acc;
      w  = (d == 0) ? 8 : 32;
      nb = 128 / w;
      if (rst_) begin
        m_head[d] = 0; m_cnt[d] = 0; m_plen[d] = 0; m_ptype[d] = 2'b00;
        m_pblk[d] = '0; m_key[d] = '0; m_chain[d] = '0; m_plain[d] = '0;
        m_kv[d] = 0; m_mode[d] = 0; m_err[d] = 0;
        m_busy[d] = 0; m_started[d] = 0; m_start[d] = 0;
      end else begin
        pre_cnt = m_cnt[d];
        pre_cfg = !m_busy[d] && (pre_cnt == 0);
        m_start[d] = 0;
        // engine job: accepted one edge, launched the next, retired on done
        if (m_busy[d] && !m_started[d]) begin
          m_start[d]   = 1;
          m_started[d] = 1;
          m_plain[d]   = m_fifo[d][m_head[d]] ^ (m_mode[d] ? m_chain[d] : 128'd0);
        end else if (m_busy[d] && i_done[d]) begin
          if (m_mode[d]) m_chain[d] = i_cipher[d];
          m_head[d] = (m_head[d] + 1) % 4;
          m_cnt[d]  = m_cnt[d] - 1;
          m_busy[d] = 0;
          m_started[d] = 0;
        end else if (!m_busy[d] && pre_cnt > 0 && m_kv[d]) begin
          m_busy[d] = 1;
        end
        if (i_cmd[d] != 2'b00) begin
          acc = (i_cmd[d] == 2'b10) ? (pre_cnt < 4) : pre_cfg;
          if (m_plen[d] > 0 && i_cmd[d] != m_ptype[d]) begin
            m_err[d]  = 1;
            m_plen[d] = 0;
          end
          if (!acc) m_err[d] = 1;
          else begin
            for (int b = 0; b < w; b++) m_pblk[d][127 - m_plen[d]*w - b] = i_din[d][w-1-b];
            m_ptype[d] = i_cmd[d];
            m_plen[d]  = m_plen[d] + 1;
            if (m_plen[d] == nb) begin
              m_plen[d] = 0;
              if (i_cmd[d] == 2'b01) begin
                m_key[d] = m_pblk[d]; m_kv[d] = 1; m_mode[d] = i_mode[d];
              end else if (i_cmd[d] == 2'b11) begin
                m_chain[d] = m_pblk[d];
              end else begin
                m_fifo[d][(m_head[d] + m_cnt[d]) % 4] = m_pblk[d];
                m_cnt[d] = m_cnt[d] + 1;
              end
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d ready", d),      128'(o_ready[d]), 128'(m_cnt[d] < 4));
        check($sformatf("d%0d cfg_ready", d),  128'(o_cfg[d]),   128'(!m_busy[d] && m_cnt[d] == 0));
        check($sformatf("d%0d start", d),      128'(o_start[d]), 128'(m_start[d]));
        check($sformatf("d%0d plain_out", d),  o_plain[d],       m_plain[d]);
        check($sformatf("d%0d key_out", d),    o_key[d],         m_key[d]);
        check($sformatf("d%0d fifo_count", d), 128'(o_cnt[d]),   128'(m_cnt[d]));
        check($sformatf("d%0d err", d),        128'(o_err[d]),   128'(m_err[d]));
      end
    end
  end

  task automatic beat(input int d, input logic [1:0] c, input logic [31:0] v);
    @(negedge clk);
    i_cmd[d] = c;
    i_din[d] = v;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    i_cmd[0] = 2'b00; i_cmd[1] = 2'b00;
    i_done[0] = 1'b0; i_done[1] = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_blk(input int d, input logic [1:0] c, input logic [127:0] blk);
    int w;
    logic [127:0] t;
    w = (d == 0) ? 8 : 32;
    for (int i = 0; i < 128 / w; i++) begin
      t = blk << (w * i);
      beat(d, c, t[127:96] >> (32 - w));
    end
  endtask

  task automatic wait_start(input int d, input int max);
    bit seen;
    seen = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (o_start[d]) seen = 1;
    end
    check($sformatf("d%0d start seen", d), 128'(seen), 128'(1));
  endtask

  task automatic pulse_done(input int d, input logic [127:0] c);
    @(negedge clk);
    i_done[d]   = 1'b1;
    i_cipher[d] = c;
    @(negedge clk);
    i_done[d]   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    for (int d = 0; d < 2; d++) begin
      i_din[d] = '0; i_cmd[d] = 2'b00; i_mode[d] = 1'b0; i_done[d] = 1'b0; i_cipher[d] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset fifo_count", 128'(o_cnt[0]), 128'd0);
    check("reset err", 128'(o_err[0]), 128'd0);
    check("reset key_out", o_key[0], 128'd0);
    check("reset cfg_ready", 128'(o_cfg[0]), 128'd1);
    #2 rst_ = 1'b0;

    // ECB, 8-bit beats: start pulse exactly two edges after the last plaintext beat
    i_mode[0] = MODE_ECB;
    send_blk(0, CMD_KEY, 128'h000102030405060708090a0b0c0d0e0f);
    send_blk(0, CMD_PT, 128'h00112233445566778899aabbccddeeff);
    idle(1);
    check("ecb start +1", 128'(o_start[0]), 128'd0);
    @(negedge clk);
    check("ecb start +2", 128'(o_start[0]), 128'd0);
    @(negedge clk);
    check("ecb start +3", 128'(o_start[0]), 128'd1);
    check("ecb plain_out", o_plain[0], 128'h00112233445566778899aabbccddeeff);
    check("ecb key_out", o_key[0], 128'h000102030405060708090a0b0c0d0e0f);
    @(negedge clk);
    check("ecb single pulse", 128'(o_start[0]), 128'd0);
    pulse_done(0, 128'h0123);
    idle(2);

    // CBC, 32-bit beats: IV xor first block, ciphertext chains into the second
    i_mode[1] = MODE_CBC;
    send_blk(1, CMD_KEY, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    send_blk(1, CMD_IV, {128{1'b1}});
    send_blk(1, CMD_PT, 128'd0);
    idle(1);
    wait_start(1, 6);
    check("cbc plain 1", o_plain[1], {128{1'b1}});
    send_blk(1, CMD_PT, 128'd0);
    idle(1);
    pulse_done(1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_start(1, 6);
    check("cbc plain 2", o_plain[1], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    pulse_done(1, {32{4'h1}});
    idle(2);
    check("cbc err clean", 128'(o_err[1]), 128'd0);

    // FIFO full: five blocks, none retired, the fifth is dropped
    check("full err before", 128'(o_err[0]), 128'd0);
    for (int k = 0; k < 5; k++) send_blk(0, CMD_PT, {4{32'h10000000 * k + 32'h00a5a5a5}});
    idle(1);
    check("full fifo_count", 128'(o_cnt[0]), 128'd4);
    check("full ready", 128'(o_ready[0]), 128'd0);
    check("full err", 128'(o_err[0]), 128'd1);
    pulse_done(0, 128'd0);
    for (int k = 0; k < 3; k++) begin
      wait_start(0, 8);
      pulse_done(0, 128'd0);
    end
    idle(2);
    check("drained fifo_count", 128'(o_cnt[0]), 128'd0);

    // Mixed commands: partial plaintext discarded, key beat becomes key beat 0
    beat(1, CMD_PT, 32'h11111111);
    beat(1, CMD_PT, 32'h22222222);
    beat(1, CMD_PT, 32'h33333333);
    beat(1, CMD_KEY, 32'hcafef00d);
    beat(1, CMD_KEY, 32'h01234567);
    beat(1, CMD_KEY, 32'h89abcdef);
    beat(1, CMD_KEY, 32'h0badc0de);
    idle(1);
    check("mix err", 128'(o_err[1]), 128'd1);
    check("mix key_out", o_key[1], 128'hcafef00d_01234567_89abcdef_0badc0de);
    check("mix fifo_count", 128'(o_cnt[1]), 128'd0);

    // Push and pop on the same edge
    send_blk(1, CMD_PT, 128'd0);
    idle(1);
    wait_start(1, 6);
    beat(1, CMD_PT, 32'd0);
    beat(1, CMD_PT, 32'd0);
    beat(1, CMD_PT, 32'd0);
    check("pp count before", 128'(o_cnt[1]), 128'd1);
    @(negedge clk);
    i_cmd[1] = CMD_PT; i_din[1] = 32'd0;
    i_done[1] = 1'b1; i_cipher[1] = 128'hdeadbeef_00000000_feedface_12345678;
    idle(1);
    check("pp count after", 128'(o_cnt[1]), 128'd1);
    wait_start(1, 6);
    check("pp plain", o_plain[1], 128'hdeadbeef_00000000_feedface_12345678);
    pulse_done(1, 128'd0);
    idle(2);

    // Reset while BUSY, then a stale engine_done
    send_blk(0, CMD_PT, 128'h5555aaaa_5555aaaa_5555aaaa_5555aaaa);
    idle(1);
    wait_start(0, 6);
    @(negedge clk);
    #2 rst_ = 1'b1;
    #1;
    check("rst start", 128'(o_start[0]), 128'd0);
    check("rst plain_out", o_plain[0], 128'd0);
    check("rst key_out", o_key[0], 128'd0);
    check("rst fifo_count", 128'(o_cnt[0]), 128'd0);
    check("rst err", 128'(o_err[0]), 128'd0);
    @(negedge clk);
    #2 rst_ = 1'b0;
    pulse_done(0, 128'hffff);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_start[0]) pulses++;
    end
    check("post-rst pulses", 128'(pulses), 128'd0);
    check("post-rst fifo_count", 128'(o_cnt[0]), 128'd0);
    check("post-rst plain_out", o_plain[0], 128'd0);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
